// File: rtl/aes_enc_fsm_controller.sv
// Iterative AES-128 encryption controller: sequences key load, rounds 1..10 and a DONE pulse.
// Optional sticky busy-request detection is built when AES_ENC_OVERRUN_DETECT_EN is defined.
module aes_enc_fsm_controller (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vaild_in,
    input  logic [127:0] key_in,
    input  logic [127:0] KeyExp_RoundKey,
    output logic         vaild_out,
    output logic         busy,
    output logic [3:0]   round_count_to_keyExp,
    output logic [127:0] KeyOut_KeyExpLoad,
    output logic [127:0] RoundKey_to_Encryptor,
    output logic [1:0]   KeyExp_control,
    output logic         Encryptor_en,
    output logic [1:0]   Encryptor_control,
    output logic         overrun
);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StLoad  = 3'b001,
        StRound = 3'b010,
        StFinal = 3'b011,
        StDone  = 3'b100
    } state_e;

    localparam logic [3:0] LastFullRound = 4'd9;
    localparam logic [3:0] LastRound     = 4'd10;

    localparam logic [1:0] KeyHold   = 2'b00;
    localparam logic [1:0] KeyLoad   = 2'b01;
    localparam logic [1:0] KeyExpand = 2'b10;

    localparam logic [1:0] EncHold    = 2'b00;
    localparam logic [1:0] EncInitial = 2'b01;
    localparam logic [1:0] EncFull    = 2'b10;
    localparam logic [1:0] EncFinal   = 2'b11;

    state_e         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [127:0]   key_q, key_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        case (state_q)
            StIdle: begin
                if (vaild_in) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                round_d = 4'd1;
                state_d = StRound;
            end
            StRound: begin
                // Saturate at the last full round so the counter can never run past 10.
                if (round_q >= LastFullRound) begin
                    round_d = LastRound;
                    state_d = StFinal;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            StFinal: begin
                round_d = LastRound;
                state_d = StDone;
            end
            StDone: begin
                round_d = 4'd0;
                if (vaild_in) begin
                    key_d   = key_in;
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                round_d = 4'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        vaild_out             = 1'b0;
        busy                  = 1'b0;
        round_count_to_keyExp = 4'd0;
        RoundKey_to_Encryptor = '0;
        KeyExp_control        = KeyHold;
        Encryptor_en          = 1'b0;
        Encryptor_control     = EncHold;
        case (state_q)
            StLoad: begin
                busy                  = 1'b1;
                round_count_to_keyExp = 4'd0;
                RoundKey_to_Encryptor = key_q;
                KeyExp_control        = KeyLoad;
                Encryptor_en          = 1'b1;
                Encryptor_control     = EncInitial;
            end
            StRound: begin
                busy                  = 1'b1;
                round_count_to_keyExp = round_q;
                RoundKey_to_Encryptor = KeyExp_RoundKey;
                KeyExp_control        = KeyExpand;
                Encryptor_en          = 1'b1;
                Encryptor_control     = EncFull;
            end
            StFinal: begin
                busy                  = 1'b1;
                round_count_to_keyExp = round_q;
                RoundKey_to_Encryptor = KeyExp_RoundKey;
                KeyExp_control        = KeyExpand;
                Encryptor_en          = 1'b1;
                Encryptor_control     = EncFinal;
            end
            StDone: begin
                vaild_out             = 1'b1;
                round_count_to_keyExp = round_q;
            end
            default: begin
                vaild_out = 1'b0;
            end
        endcase
    end

    assign KeyOut_KeyExpLoad = key_q;

`ifdef AES_ENC_OVERRUN_DETECT_EN
    logic overrun_q;

    // A request while busy is dropped; remember that it happened until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (vaild_in && (state_q == StLoad || state_q == StRound ||
                                  state_q == StFinal)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_aes_enc_fsm_controller.sv
// Self-checking bench for aes_enc_fsm_controller: run-position reference model, directed
// scenarios with literal expectations, then randomized requests.
module tb_aes_enc_fsm_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vaild_in = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] rk = '0;
    logic         vaild_out, busy, Encryptor_en, overrun;
    logic [3:0]   round_count_to_keyExp;
    logic [127:0] KeyOut_KeyExpLoad, RoundKey_to_Encryptor;
    logic [1:0]   KeyExp_control, Encryptor_control;

    int n_checks = 0;
    int n_fail   = 0;
    bit echo     = 1'b1;
    int cyc      = 0;
    int pulses[$];

    aes_enc_fsm_controller dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .vaild_in              (vaild_in),
        .key_in                (key_in),
        .KeyExp_RoundKey       (rk),
        .vaild_out             (vaild_out),
        .busy                  (busy),
        .round_count_to_keyExp (round_count_to_keyExp),
        .KeyOut_KeyExpLoad     (KeyOut_KeyExpLoad),
        .RoundKey_to_Encryptor (RoundKey_to_Encryptor),
        .KeyExp_control        (KeyExp_control),
        .Encryptor_en          (Encryptor_en),
        .Encryptor_control     (Encryptor_control),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vaild_out"}, 128'(vaild_out), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_round"}, 128'(round_count_to_keyExp), 128'd0);
        check({tag, "_kexp_ctl"}, 128'(KeyExp_control), 128'd0);
        check({tag, "_enc_en"}, 128'(Encryptor_en), 128'd0);
        check({tag, "_enc_ctl"}, 128'(Encryptor_control), 128'd0);
        check({tag, "_keyout"}, KeyOut_KeyExpLoad, 128'd0);
        check({tag, "_rkout"}, RoundKey_to_Encryptor, 128'd0);
        check({tag, "_overrun"}, 128'(overrun), 128'd0);
    endtask

    // Reference model: m_pos is the 1-based cycle index inside a run (0 when idle);
    // a run is 12 cycles long: load, nine full rounds, final round, done.
    int           m_pos;
    logic [127:0] m_key;
    logic         m_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0;
            m_key <= '0;
            m_ovr <= 1'b0;
        end else if ((m_pos == 0 || m_pos == 12) && vaild_in) begin
            m_pos <= 1;
            m_key <= key_in;
        end else if (m_pos >= 1 && m_pos <= 11) begin
            m_pos <= m_pos + 1;
`ifdef AES_ENC_OVERRUN_DETECT_EN
            if (vaild_in) m_ovr <= 1'b1;
`endif
        end else begin
            m_pos <= 0;
        end
    end

    always @(negedge clk) begin : compare
        int           e_round, e_kc, e_ec;
        bit           e_act;
        logic [127:0] e_rk;
        e_act   = (m_pos >= 1 && m_pos <= 11);
        e_round = (m_pos == 0) ? 0 : (m_pos == 12) ? 10 : m_pos - 1;
        e_kc    = (m_pos == 1) ? 1 : e_act ? 2 : 0;
        e_ec    = (m_pos == 1) ? 1 : (m_pos == 11) ? 3 : e_act ? 2 : 0;
        e_rk    = (m_pos == 1) ? m_key : e_act ? rk : '0;
        check("m_vaild_out", 128'(vaild_out), 128'(m_pos == 12));
        check("m_busy", 128'(busy), 128'(e_act));
        check("m_enc_en", 128'(Encryptor_en), 128'(e_act));
        check("m_round", 128'(round_count_to_keyExp), 128'(e_round));
        check("m_kexp_ctl", 128'(KeyExp_control), 128'(e_kc));
        check("m_enc_ctl", 128'(Encryptor_control), 128'(e_ec));
        check("m_keyout", KeyOut_KeyExpLoad, m_key);
        check("m_rkout", RoundKey_to_Encryptor, e_rk);
        check("m_overrun", 128'(overrun), 128'(m_ovr));
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (vaild_out === 1'b1) pulses.push_back(cyc);

    // Key-expansion stand-in: echoes the loaded key, or returns fresh random words.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk = echo ? KeyOut_KeyExpLoad : {$urandom, $urandom, $urandom, $urandom};
        end
    end

    initial begin
        logic [127:0] k1, k2, k3, k6;
        int           np, c0;
        k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k2 = 128'h000102030405060708090a0b0c0d0e0f;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_vaild_out", 128'(vaild_out), 128'd0);

        // Single run with literal sequence, then back-to-back accept in DONE
        vaild_in = 1'b1;
        key_in   = k1;
        tick();
        vaild_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) tick();
            if (i == 12) begin
                vaild_in = 1'b1;
                key_in   = k2;
            end
            @(negedge clk);
            check("run_round", 128'(round_count_to_keyExp),
                  128'((i == 1) ? 0 : (i == 12) ? 10 : i - 1));
            check("run_kexp_ctl", 128'(KeyExp_control),
                  128'((i == 1) ? 1 : (i <= 11) ? 2 : 0));
            check("run_enc_ctl", 128'(Encryptor_control),
                  128'((i == 1) ? 1 : (i <= 10) ? 2 : (i == 11) ? 3 : 0));
            check("run_vaild_out", 128'(vaild_out), 128'(i == 12));
            check("run_keyout", KeyOut_KeyExpLoad, k1);
            check("run_rkout", RoundKey_to_Encryptor, (i <= 11) ? k1 : 128'd0);
        end
        tick();
        vaild_in = 1'b0;
        @(negedge clk);
        check("b2b_load_busy", 128'(busy), 128'd1);
        check("b2b_load_round", 128'(round_count_to_keyExp), 128'd0);
        check("b2b_load_kexp", 128'(KeyExp_control), 128'd1);
        check("b2b_load_key", KeyOut_KeyExpLoad, k2);
        check("b2b_load_rk", RoundKey_to_Encryptor, k2);
        repeat (13) tick();
        check("b2b_pulse_count", 128'(pulses.size()), 128'd2);
        if (pulses.size() == 2)
            check("b2b_spacing", 128'(pulses[1] - pulses[0]), 128'd12);

        // Request while busy at round 4
        np       = pulses.size();
        k3       = {$urandom, $urandom, $urandom, $urandom};
        vaild_in = 1'b1;
        key_in   = k3;
        tick();
        c0       = cyc;
        vaild_in = 1'b0;
        repeat (4) tick();
        check("busy_req_round", 128'(round_count_to_keyExp), 128'd4);
        vaild_in = 1'b1;
        key_in   = ~k3;
        tick();
        vaild_in = 1'b0;
        @(negedge clk);
`ifdef AES_ENC_OVERRUN_DETECT_EN
        check("busy_req_overrun", 128'(overrun), 128'd1);
`else
        check("busy_req_overrun", 128'(overrun), 128'd0);
`endif
        repeat (12) tick();
        check("busy_req_pulses", 128'(pulses.size() - np), 128'd1);
        if (pulses.size() == np + 1)
            check("busy_req_latency", 128'(pulses[$] - c0), 128'd11);
        check("busy_req_keyout", KeyOut_KeyExpLoad, k3);

        // Reset abort at round 5, then a clean run
        np       = pulses.size();
        vaild_in = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        vaild_in = 1'b0;
        repeat (5) tick();
        check("abort_round", 128'(round_count_to_keyExp), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (14) tick();
        check("abort_no_pulse", 128'(pulses.size() - np), 128'd0);
        vaild_in = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        c0       = cyc;
        vaild_in = 1'b0;
        repeat (12) tick();
        check("after_abort_pulses", 128'(pulses.size() - np), 128'd1);
        if (pulses.size() == np + 1)
            check("after_abort_latency", 128'(pulses[$] - c0), 128'd11);

        // key_in change mid-run must not leak into the captured key
        k6       = {$urandom, $urandom, $urandom, $urandom};
        vaild_in = 1'b1;
        key_in   = k6;
        tick();
        vaild_in = 1'b0;
        repeat (3) tick();
        key_in = '1;
        @(negedge clk);
        check("keystab_round", 128'(round_count_to_keyExp), 128'd3);
        check("keystab_mid", KeyOut_KeyExpLoad, k6);
        repeat (8) tick();
        @(negedge clk);
        check("keystab_done", 128'(vaild_out), 128'd1);
        check("keystab_end", KeyOut_KeyExpLoad, k6);
        tick();

        // Randomized requests and keys against the model
        echo = 1'b0;
        for (int i = 0; i < 400; i++) begin
            vaild_in = ($urandom_range(3) == 0);
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        vaild_in = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
